// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and helpers for the debounced register-map input path.
//   deb_state_t : debounce FSM state encoding
//   deb_cnt_w() : width of the stability counter for a given stable-cycle count
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        PEND_HI = 2'd1,
        ST_HI   = 2'd2,
        PEND_LO = 2'd3
    } deb_state_t;

    // clog2(stable_cycles), never less than 1 so the counter always exists.
    // The counter only ever holds 0..stable_cycles-1, which this width covers.
    function automatic int deb_cnt_w(input int stable_cycles);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(stable_cycles)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : debounce_pkg

// File: rtl/debounce_sync_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Multi-flop synchronizer for a single asynchronous bit. Kept as its own
// module so the flops can be targeted by async-register constraints and the
// block can be reused for other register-map inputs.
// Ports:
//   clk : sampling clock
//   rst : synchronous active-high reset, loads RST_VAL into every stage
//   d   : asynchronous input
//   q   : synchronized output (last stage)
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
// Synchronizes and debounces one bouncy asynchronous input. A new level is
// accepted only after STABLE_CYCLES consecutive synchronized samples agree;
// aborted candidates are counted in a saturating glitch counter.
// Ports:
//   clk          : single clock
//   rst          : synchronous active-high reset
//   raw          : asynchronous, possibly bouncy input
//   enable       : 1 = debounce active, 0 = hold val_out and drop any candidate
//   glitch_clr   : one-cycle clear of glitch_count (wins over a same-cycle glitch)
//   val_out      : debounced level (registered)
//   busy         : candidate level pending (registered)
//   glitch_count : saturating count of rejected candidates (registered)
// -----------------------------------------------------------------------------
module debounce_sync
    import debounce_pkg::*;
#(
    parameter logic DEFAULT       = 1'b0,
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter int   GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                raw,
    input  logic                enable,
    input  logic                glitch_clr,
    output logic                val_out,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int                  CNT_W      = deb_cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_FIRST  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
    localparam deb_state_t          RST_STATE  = DEFAULT ? ST_HI : ST_LO;

    logic                s;
    deb_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                val_q, val_d;
    logic                busy_q, busy_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                glitch_evt;

    sync_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (DEFAULT)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw),
        .q   (s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        val_d      = val_q;
        glitch_evt = 1'b0;

        if (!enable) begin
            // Fall back to the stable state matching the held level; an
            // aborted candidate here is not a glitch.
            state_d = val_q ? ST_HI : ST_LO;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_LO: begin
                    if (s) begin
                        state_d = PEND_HI;
                        cnt_d   = CNT_FIRST;
                    end
                end
                ST_HI: begin
                    if (!s) begin
                        state_d = PEND_LO;
                        cnt_d   = CNT_FIRST;
                    end
                end
                PEND_HI: begin
                    if (s) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_HI;
                            val_d   = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d    = ST_LO;
                        cnt_d      = '0;
                        glitch_evt = 1'b1;
                    end
                end
                PEND_LO: begin
                    if (!s) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_LO;
                            val_d   = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d    = ST_HI;
                        cnt_d      = '0;
                        glitch_evt = 1'b1;
                    end
                end
                default: begin
                    state_d = RST_STATE;
                    cnt_d   = '0;
                end
            endcase
        end

        // busy is registered, so it is derived from the next state.
        busy_d = (state_d == PEND_HI) || (state_d == PEND_LO);

        if (glitch_clr) begin
            glitch_d = '0;
        end else if (glitch_evt && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + 1'b1;
        end else begin
            glitch_d = glitch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            val_q    <= DEFAULT;
            busy_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            val_q    <= val_d;
            busy_q   <= busy_d;
            glitch_q <= glitch_d;
        end
    end

    assign val_out      = val_q;
    assign busy         = busy_q;
    assign glitch_count = glitch_q;

endmodule : debounce_sync
